// File: rtl/snn_neuron_accum.sv
// Per-channel saturating membrane accumulator with a leak/threshold/refractory timestep FSM.
// Step takes 2 cycles (LEAK, FIRE); accumulates arriving while busy are discarded and flagged on o_drop.
module snn_neuron_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = 16,
  parameter int N_CH       = 4,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_acc_valid,
  input  logic [CH_W-1:0]               i_acc_ch,
  input  logic signed [DATA_WIDTH-1:0]  i_data_in,
  input  logic                          i_step,
  input  logic signed [SUM_WIDTH-1:0]   i_threshold,
  output logic                          o_busy,
  output logic                          o_drop,
  output logic [N_CH-1:0]               o_spike,
  output logic                          o_spike_valid,
  output logic [N_CH*SUM_WIDTH-1:0]     o_sum,
  output logic [N_CH-1:0]               o_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEAK = 2'd1,
    S_FIRE = 2'd2
  } state_t;

  localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  localparam logic [3:0]                  REF_LOAD = 4'(REFRAC);

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_drop;
  logic                        r_spike_valid;
  logic [N_CH-1:0]             r_spike;
  logic [N_CH-1:0]             r_sat;
  logic signed [SUM_WIDTH-1:0] r_sum [N_CH];
  logic [3:0]                  r_ref [N_CH];

  logic                        w_ch_ok;
  logic                        w_acc_ok;
  logic signed [SUM_WIDTH:0]   w_add;
  logic                        w_add_ovf;
  logic signed [SUM_WIDTH-1:0] w_add_sat;
  logic signed [SUM_WIDTH-1:0] w_leak [N_CH];
  logic [N_CH-1:0]             w_fire;

  // One extra guard bit on the add; overflow shows up as the top two bits disagreeing.
  always_comb begin
    w_ch_ok   = ({{(32-CH_W){1'b0}}, i_acc_ch} < N_CH);
    w_acc_ok  = 1'b0;
    w_add     = '0;
    if (w_ch_ok) begin
      w_add    = {r_sum[i_acc_ch][SUM_WIDTH-1], r_sum[i_acc_ch]}
               + {{(SUM_WIDTH+1-DATA_WIDTH){i_data_in[DATA_WIDTH-1]}}, i_data_in};
      w_acc_ok = (r_ref[i_acc_ch] == 4'd0);
    end
    w_add_ovf = w_add[SUM_WIDTH] ^ w_add[SUM_WIDTH-1];
    w_add_sat = w_add_ovf ? (w_add[SUM_WIDTH] ? SUM_MIN : SUM_MAX) : w_add[SUM_WIDTH-1:0];
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      w_leak[c] = (LEAK_SHIFT == 0) ? r_sum[c] : r_sum[c] - (r_sum[c] >>> LEAK_SHIFT);
      w_fire[c] = (r_sum[c] >= i_threshold) && (r_ref[c] == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_drop        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike       <= '0;
      r_sat         <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_sum[c] <= '0;
        r_ref[c] <= '0;
      end
    end else if (i_clear) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_drop        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike       <= '0;
      r_sat         <= '0;
      for (int c = 0; c < N_CH; c++) begin
        r_sum[c] <= '0;
        r_ref[c] <= '0;
      end
    end else begin
      r_drop        <= 1'b0;
      r_spike_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Applied on the same edge as a step so the leak sees the updated sum.
          if (i_acc_valid && w_ch_ok && w_acc_ok) begin
            r_sum[i_acc_ch] <= w_add_sat;
            if (w_add_ovf) r_sat[i_acc_ch] <= 1'b1;
          end
          if (i_step) begin
            r_state <= S_LEAK;
            r_busy  <= 1'b1;
          end
        end
        S_LEAK: begin
          r_drop <= i_acc_valid && w_ch_ok;
          for (int c = 0; c < N_CH; c++) begin
            r_sum[c] <= w_leak[c];
            if (r_ref[c] != 4'd0) r_ref[c] <= r_ref[c] - 4'd1;
          end
          r_state <= S_FIRE;
        end
        S_FIRE: begin
          r_drop <= i_acc_valid && w_ch_ok;
          for (int c = 0; c < N_CH; c++) begin
            if (w_fire[c]) begin
              r_spike[c] <= 1'b1;
              r_sum[c]   <= '0;
              r_ref[c]   <= REF_LOAD;
            end else begin
              r_spike[c] <= 1'b0;
            end
          end
          r_spike_valid <= 1'b1;
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_drop        = r_drop;
  assign o_spike       = r_spike;
  assign o_spike_valid = r_spike_valid;
  assign o_sat         = r_sat;

  for (genvar g = 0; g < N_CH; g++) begin : g_sum
    assign o_sum[g*SUM_WIDTH +: SUM_WIDTH] = r_sum[g];
  end

endmodule

// File: doc/snn_neuron_accum.md
Name: snn_neuron_accum

Overview:
- Multi-channel successor to the single-sum accumulator; sits between the synapse memory controller and the main controller.
- Holds one signed membrane sum per output neuron and accumulates signed weights per channel with saturation.
- On a timestep strobe, applies shift-based leak, compares each sum to a threshold, emits a spike vector and enforces a refractory period.

Parameters:
- DATA_WIDTH, 8: signed weight width.
- SUM_WIDTH, 16: signed membrane sum width; must be greater than DATA_WIDTH.
- N_CH, 4: number of neuron channels. CH_W = max(1, $clog2(N_CH)) is a derived localparam.
- LEAK_SHIFT, 4: leak per step is v - (v>>>LEAK_SHIFT). A value of 0 disables leak.
- REFRAC, 2: refractory length in timesteps, range 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_clear  in  1  synchronous clear of all state; highest priority
- i_acc_valid  in  1  accumulate request
- i_acc_ch  in  CH_W  target channel
- i_data_in  in  DATA_WIDTH  signed weight
- i_step  in  1  end-of-timestep strobe
- i_threshold  in  SUM_WIDTH  signed fire threshold, sampled in FIRE
- o_busy  out  1  step in progress
- o_drop  out  1  one-cycle pulse: accumulate rejected because busy
- o_spike  out  N_CH  spike vector, held until the next step or clear
- o_spike_valid  out  1  one-cycle pulse: o_spike updated
- o_sum  out  N_CH*SUM_WIDTH  packed sums; channel c occupies [c*SUM_WIDTH +: SUM_WIDTH]
- o_sat  out  N_CH  sticky per-channel saturation flag

Behaviour:
- Reset: all sums 0, refractory counters 0, o_spike 0, o_sat 0, o_busy 0, o_drop 0, o_spike_valid 0, FSM in IDLE.
- FSM states and transitions:
  - IDLE -> LEAK on i_step.
  - LEAK -> FIRE unconditionally.
  - FIRE -> IDLE unconditionally.
  - o_busy = (state != IDLE), registered.
- Accumulate (IDLE only):
  - When i_acc_valid and the channel's refractory counter is 0, sum[ch] <= sat(sum[ch] + sign-extended i_data_in).
  - Saturation clamps to [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1] and sets o_sat[ch]; o_sat bits clear only on reset or i_clear.
  - i_acc_ch >= N_CH: request ignored, no drop pulse.
  - Refractory channel: request silently ignored.
- Accumulate while busy: ignored; o_drop is asserted in the next cycle for one cycle.
- i_acc_valid and i_step in the same IDLE cycle: the accumulation is applied on that edge, so the step sees the updated sum.
- LEAK cycle:
  - Every sum <= v - (v>>>LEAK_SHIFT), arithmetic shift; no saturation is possible.
  - Every nonzero refractory counter decrements by 1.
- FIRE cycle, per channel:
  - Fires when v >= i_threshold (signed compare) and the refractory counter is 0.
  - On fire: o_spike[c] <= 1, sum <= 0, counter <= REFRAC. Otherwise o_spike[c] <= 0.
  - o_spike_valid pulses in the cycle after FIRE.
- Latency: i_step seen at edge k; leak applied at k+1; spikes registered at k+2; o_spike_valid high during cycle k+2..k+3. o_busy is high from k to k+2.
- i_step while busy: ignored.
- i_clear in any state:
  - Zeros sums, counters, o_spike and o_sat.
  - Returns the FSM to IDLE and aborts any step in progress; no o_spike_valid pulse follows.
  - Same-cycle i_acc_valid and i_step are ignored.
- Asynchronous reset mid-step behaves identically to i_clear.

Test Plan:
- Reset with all inputs 0 -> o_sum all 0, o_spike 0, o_busy 0, o_sat 0.
- ch1 receives +100 three times (sum 300); i_step with threshold 250 -> leak gives 282, o_spike=4'b0010 with one o_spike_valid pulse 2 cycles after step, ch1 sum 0, other channels unchanged. Repeat with threshold 300 -> no spike, ch1 sum 282.
- Saturation: ch0 receives +127 for 300 cycles -> sum 32767, o_sat[0]=1. ch2 receives -128 for 300 cycles -> sum -32768, o_sat[2]=1. Then i_clear -> o_sat 0.
- Refractory: after ch1 fires, +100 to ch1 is ignored across 2 steps and ch1 does not fire. After the second step, +100 is accepted (sum 100).
- Accumulate to ch3 during LEAK -> o_drop pulses once, ch3 sum unchanged. Same-cycle +50 to ch3 and i_step in IDLE -> leak operates on 50, giving 47.
- i_clear asserted in the FIRE cycle with ch1 above threshold -> no o_spike_valid, o_spike 0, all sums 0, o_busy 0 the next cycle.
